// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver feeding a (2**FIFO_BITS)-1 byte RX FIFO read through a stb/ack port.
// Optional build macro UART_RX_ERR_EN adds sticky frame/overrun error flags and err_clr_i.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 62,
    parameter int unsigned FIFO_BITS    = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       stb_i,
    output logic [7:0] data_o,
    output logic       ack_o,
    output logic       data_ready_o,
`ifdef UART_RX_ERR_EN
    input  logic       err_clr_i,
    output logic       frame_err_o,
    output logic       overrun_err_o,
`endif
    input  logic       uart_rxd_i
);

    localparam int unsigned Depth   = 2 ** FIFO_BITS;
    localparam logic [15:0] HalfBit = 16'(CLKS_PER_BIT / 2);
    localparam logic [15:0] LastCnt = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        RxIdle,
        RxStartBit,
        RxDataBits,
        RxStopBit
    } rx_state_e;

    rx_state_e            state_q, state_d;
    logic                 rxd_meta_q, rxd_s;
    logic [15:0]          cnt_q, cnt_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [7:0]           shift_q, shift_d;
    logic                 stop_sample;

    logic [7:0]           fifo_mem [Depth];
    logic [FIFO_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic                 fifo_empty, fifo_full;
    logic                 push, pop;
    logic                 pending_q, pending_d;
    logic                 ack_q;
    logic [7:0]           data_q;
    logic                 data_ready_q;

    // Two-flop synchronizer; idles high so reset never looks like a start bit.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rxd_meta_q <= 1'b1;
            rxd_s      <= 1'b1;
        end else begin
            rxd_meta_q <= uart_rxd_i;
            rxd_s      <= rxd_meta_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= RxIdle;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        stop_sample = 1'b0;
        case (state_q)
            RxIdle: begin
                if (!rxd_s) begin
                    cnt_d   = '0;
                    state_d = RxStartBit;
                end
            end
            RxStartBit: begin
                if (cnt_q == HalfBit) begin
                    cnt_d = '0;
                    if (!rxd_s) begin
                        bit_idx_d = '0;
                        state_d   = RxDataBits;
                    end else begin
                        state_d = RxIdle;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            RxDataBits: begin
                // Counter restarts at mid start bit, so LastCnt lands on mid data bit.
                if (cnt_q == LastCnt) begin
                    cnt_d   = '0;
                    shift_d = {rxd_s, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = RxStopBit;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            RxStopBit: begin
                // Return to idle at mid stop bit so the next start edge is never missed.
                if (cnt_q == LastCnt) begin
                    cnt_d       = '0;
                    stop_sample = 1'b1;
                    state_d     = RxIdle;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = RxIdle;
        endcase
    end

    assign fifo_empty = (rd_ptr_q == wr_ptr_q);
    assign fifo_full  = (rd_ptr_q == wr_ptr_q + FIFO_BITS'(1));

    // Full is judged on current pointers, so a same-cycle pop never rescues a push.
    assign push = stop_sample & rxd_s & ~fifo_full;
    assign pop  = (stb_i | pending_q) & ~ack_q & ~fifo_empty;

    always_comb begin
        wr_ptr_d  = push ? wr_ptr_q + FIFO_BITS'(1) : wr_ptr_q;
        rd_ptr_d  = pop  ? rd_ptr_q + FIFO_BITS'(1) : rd_ptr_q;
        pending_d = pending_q;
        if (pop) begin
            pending_d = 1'b0;
        end else if (stb_i) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= shift_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            pending_q    <= 1'b0;
            ack_q        <= 1'b0;
            data_q       <= 8'h00;
            data_ready_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            pending_q    <= pending_d;
            ack_q        <= pop;
            data_ready_q <= (wr_ptr_d != rd_ptr_d);
            if (pop) begin
                data_q <= fifo_mem[rd_ptr_q];
            end
        end
    end

    assign data_o       = data_q;
    assign ack_o        = ack_q;
    assign data_ready_o = data_ready_q;

`ifdef UART_RX_ERR_EN
    logic frame_err_q, overrun_err_q;
    logic frame_evt, overrun_evt;

    assign frame_evt   = stop_sample & ~rxd_s;
    assign overrun_evt = stop_sample & rxd_s & fifo_full;

    // A coincident event beats the clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            frame_err_q   <= 1'b0;
            overrun_err_q <= 1'b0;
        end else begin
            frame_err_q   <= frame_evt | (frame_err_q & ~err_clr_i);
            overrun_err_q <= overrun_evt | (overrun_err_q & ~err_clr_i);
        end
    end

    assign frame_err_o   = frame_err_q;
    assign overrun_err_o = overrun_err_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed plus randomized frames against a byte-queue model of the RX FIFO.
// Error-flag checks are compiled in when UART_RX_ERR_EN is defined.
module tb_uart_rx;

    localparam int unsigned Cpb      = 8;
    localparam int unsigned FifoBits = 4;
    localparam int unsigned Capacity = (2 ** FifoBits) - 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       stb = 1'b0;
    logic       rxd = 1'b1;
    logic [7:0] data;
    logic       ack;
    logic       data_ready;
`ifdef UART_RX_ERR_EN
    logic       err_clr = 1'b0;
    logic       frame_err, overrun_err;
    logic       m_frame_err, m_overrun;
`endif

    int         n_checks = 0;
    int         n_fail   = 0;
    int         ack_cnt  = 0;
    logic [7:0] ack_data [$];
    logic [7:0] model [$];

    uart_rx #(
        .CLKS_PER_BIT(Cpb),
        .FIFO_BITS   (FifoBits)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .stb_i        (stb),
        .data_o       (data),
        .ack_o        (ack),
        .data_ready_o (data_ready),
`ifdef UART_RX_ERR_EN
        .err_clr_i    (err_clr),
        .frame_err_o  (frame_err),
        .overrun_err_o(overrun_err),
`endif
        .uart_rxd_i   (rxd)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #2;
        if (ack) begin
            ack_cnt++;
            ack_data.push_back(data);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish, expected finish before 2ms");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drives one frame (called on a negedge) and applies the FIFO rules to the model.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rxd = bits[i];
            repeat (Cpb) @(negedge clk);
        end
        rxd = 1'b1;
        if (!stop) begin
`ifdef UART_RX_ERR_EN
            m_frame_err = 1'b1;
`endif
        end else if (model.size() >= Capacity) begin
`ifdef UART_RX_ERR_EN
            m_overrun = 1'b1;
`endif
        end else begin
            model.push_back(b);
        end
    endtask

    task automatic check_pop(input string tag);
        logic [7:0] exp_b, got_b;
        exp_b = model.pop_front();
        got_b = (ack_data.size() != 0) ? ack_data.pop_front() : 8'hxx;
        check_eq(tag, {24'h0, got_b}, {24'h0, exp_b});
    endtask

    // Single-cycle strobe, wait for the ack and compare against the model head.
    task automatic read_byte(input string tag);
        int start;
        start = ack_cnt;
        stb = 1'b1;
        @(negedge clk);
        stb = 1'b0;
        for (int i = 0; i < 20 && ack_cnt == start; i++) @(negedge clk);
        check_eq({tag, "_ackcnt"}, ack_cnt - start, 1);
        check_pop({tag, "_data"});
        check_eq({tag, "_ready"}, {31'h0, data_ready}, {31'h0, model.size() != 0});
        @(negedge clk);
        check_eq({tag, "_ackpulse"}, {31'h0, ack}, 32'h0);
    endtask

`ifdef UART_RX_ERR_EN
    task automatic check_errs(input string tag);
        check_eq({tag, "_ferr"}, {31'h0, frame_err}, {31'h0, m_frame_err});
        check_eq({tag, "_oerr"}, {31'h0, overrun_err}, {31'h0, m_overrun});
    endtask
`endif

    task automatic do_reset();
        rxd = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model.delete();
        ack_data.delete();
`ifdef UART_RX_ERR_EN
        m_frame_err = 1'b0;
        m_overrun   = 1'b0;
`endif
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int start;
        @(negedge clk);
        do_reset();
        check_eq("rst_ack", {31'h0, ack}, 32'h0);
        check_eq("rst_data", {24'h0, data}, 32'h0);
        check_eq("rst_ready", {31'h0, data_ready}, 32'h0);
`ifdef UART_RX_ERR_EN
        check_errs("rst");
`endif

        // 1: single frame then read
        send_frame(8'hA5, 1'b1);
        check_eq("t1_ready", {31'h0, data_ready}, 32'h1);
        read_byte("t1");

        // 2: read on empty FIFO stays pending until a byte arrives
        start = ack_cnt;
        stb = 1'b1;
        @(negedge clk);
        stb = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("t2_noack_empty", ack_cnt - start, 0);
        send_frame(8'h3C, 1'b1);
        repeat (10) @(negedge clk);
        check_eq("t2_ackcnt", ack_cnt - start, 1);
        check_pop("t2_data");
        repeat (40) @(negedge clk);
        check_eq("t2_no_extra_ack", ack_cnt - start, 1);
        check_eq("t2_ready", {31'h0, data_ready}, 32'h0);

        // 3: overrun, sixteen frames into a fifteen-byte FIFO
        for (int i = 0; i < 16; i++) send_frame(8'(i), 1'b1);
`ifdef UART_RX_ERR_EN
        check_errs("t3");
`endif
        for (int i = 0; i < 15; i++) read_byte($sformatf("t3_rd%0d", i));
        check_eq("t3_empty", {31'h0, data_ready}, 32'h0);

        // 4: short glitch is rejected
        start = ack_cnt;
        rxd = 1'b0;
        repeat (3) @(negedge clk);
        rxd = 1'b1;
        repeat (30) @(negedge clk);
        check_eq("t4_ready", {31'h0, data_ready}, 32'h0);
        send_frame(8'h6E, 1'b1);
        read_byte("t4_after");

        // 5: framing error
        send_frame(8'h55, 1'b0);
        repeat (20) @(negedge clk);
        check_eq("t5_ready", {31'h0, data_ready}, 32'h0);
`ifdef UART_RX_ERR_EN
        check_errs("t5");
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        m_frame_err = 1'b0;
        m_overrun   = 1'b0;
        check_errs("t5_clr");
`endif

        // 6: reset mid-frame, then a clean frame
        rxd = 1'b0;
        repeat (Cpb) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rxd = (i == 0);
            repeat (Cpb) @(negedge clk);
        end
        do_reset();
        repeat (2 * Cpb) @(negedge clk);
        check_eq("t6_ready_rst", {31'h0, data_ready}, 32'h0);
        send_frame(8'h81, 1'b1);
        read_byte("t6");

        // Randomized frames, reads and double strobes against the model.
        for (int it = 0; it < 40; it++) begin
            logic [7:0] b;
            logic       stop;
            b    = 8'($urandom);
            stop = ($urandom_range(0, 7) != 0);
            send_frame(b, stop);
            repeat (stop ? $urandom_range(0, 12) : 2 * Cpb) @(negedge clk);
            check_eq($sformatf("rnd%0d_ready", it), {31'h0, data_ready},
                     {31'h0, model.size() != 0});
`ifdef UART_RX_ERR_EN
            check_errs($sformatf("rnd%0d", it));
            if ($urandom_range(0, 3) == 0) begin
                err_clr = 1'b1;
                @(negedge clk);
                err_clr = 1'b0;
                m_frame_err = 1'b0;
                m_overrun   = 1'b0;
            end
`endif
            if (model.size() >= 2 && $urandom_range(0, 3) == 0) begin
                // Strobe held into the ack cycle becomes a pending request.
                start = ack_cnt;
                stb = 1'b1;
                repeat (2) @(negedge clk);
                stb = 1'b0;
                repeat (6) @(negedge clk);
                check_eq($sformatf("rnd%0d_dbl_acks", it), ack_cnt - start, 2);
                check_pop($sformatf("rnd%0d_dbl0", it));
                check_pop($sformatf("rnd%0d_dbl1", it));
            end else begin
                for (int r = $urandom_range(0, 2); r > 0 && model.size() != 0; r--)
                    read_byte($sformatf("rnd%0d_rd", it));
            end
        end
        while (model.size() != 0) read_byte("drain");
        check_eq("final_ready", {31'h0, data_ready}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
